// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide sequencer.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // funct3[2] selects the divide family; funct3[0] marks the unsigned divide variants.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> M-unit signal bundle. Handshake: the pipeline asserts start with operands
// in IDLE; the unit answers with stall while working and a one-cycle done with result.
interface mdu_if #(parameter int XLEN = 32);
    logic             start;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic             stall;
    mdu_pkg::state_e  state;

    modport master (
        output start, funct3, a, b, flush,
        input  busy, done, result, stall, state
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output busy, done, result, stall, state
    );
endinterface

// File: rtl/mdu_signfix.sv
// Turns the unsigned iteration output (product, or remainder:quotient) into the final
// RV32M result, applying operand signs and the divide exception values.
module mdu_signfix
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2*XLEN-1:0] raw,
    input  logic              sa,
    input  logic              sb,
    input  logic              div0,
    input  logic              ovf,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;

    always_comb begin
        prod_s = (sa ^ sb) ? -raw : raw;
        quot_s = (sa ^ sb) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        // Remainder takes the dividend's sign; for x/0 this reproduces a itself.
        rem_s  = sa ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        result = '0;
        case (funct3)
            F3_MUL:                      result = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             result = ovf ? INT_MIN : (div0 ? DIV0_Q : quot_s);
            F3_REM, F3_REMU:             result = ovf ? '0 : rem_s;
            default:                     result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply / restoring divide on operand
// magnitudes, with sign correction in FIN and a pipeline stall while busy.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_EXC = 1'b1
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              div0_q, div0_d, ovf_q, ovf_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   fix_result;

    logic              in_div, a_signed, b_signed, in_sa, in_sb, in_div0, in_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next;

    // Operand decode for the start cycle.
    always_comb begin
        in_div   = is_div(bus.funct3);
        a_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                   (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
        b_signed = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
                   (bus.funct3 == F3_REM);
        in_sa    = a_signed & bus.a[XLEN-1];
        in_sb    = b_signed & bus.b[XLEN-1];
        abs_a    = in_sa ? -bus.a : bus.a;
        abs_b    = in_sb ? -bus.b : bus.b;
        in_div0  = in_div & (bus.b == '0);
        in_ovf   = in_div & ~bus.funct3[0] & (bus.a == INT_MIN) & (bus.b == DIV0_Q);
    end

    // One iteration step. acc holds {product_hi, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        // When div_ge holds the true difference is below the divisor, so 32-bit wrap is exact.
        div_sub   = div_shift[XLEN-1:0] - opnd_q;
        div_next  = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.funct3;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    div0_d  = in_div0;
                    ovf_d   = in_ovf;
                    cnt_d   = '0;
                    opnd_d  = in_div ? abs_b : abs_a;
                    acc_d   = in_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                    state_d = ST_CALC;
                    if (FAST_EXC && (in_div0 || in_ovf)) begin
                        acc_d   = {abs_a, {XLEN{1'b0}}};
                        state_d = ST_FIN;
                    end
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                result_d = fix_result;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    mdu_signfix #(.XLEN(XLEN)) u_signfix (
        .funct3 (op_q),
        .raw    (acc_q),
        .sa     (sa_q),
        .sb     (sb_q),
        .div0   (div0_q),
        .ovf    (ovf_q),
        .result (fix_result)
    );

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.state  = state_q;
    assign bus.stall  = busy_q | (bus.start & (state_q == ST_IDLE) & ~bus.flush);

endmodule
